score_keeper: RTL and testbench
===============================

Name: score_keeper

Overview:
- Judgement/scoring stage directly downstream of the chart/note engine.
- Consumes per-lane note_active/note_hit and chart_done; classifies each note as hit or miss.
- Maintains combo, max combo, hit/miss counts and a 4-digit BCD score for the 7-segment display.
- At chart end, drains pending points and issues a letter grade with a results_valid flag.

Parameters:
- POINTS_PER_HIT, 10, points credited per hit note.
- COMBO_BONUS_THRESH, 8, combo length (after the current hit) at and above which each hit earns a bonus.
- COMBO_BONUS_POINTS, 5, extra points per hit while the combo bonus applies.
- GRADE_A_MAX_MISS, 2, maximum misses for grade A.
- GRADE_B_MAX_MISS, 8, maximum misses for grade B.
- FC_BONUS, 100, full-combo bonus points (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- note_active  in  4  per-lane note-present flags from the chart engine
- note_hit  in  4  per-lane hit flags from the chart engine
- chart_done  in  1  chart finished, level
- score_bcd  out  16  4 BCD digits, [15:12] is the thousands digit
- combo  out  8  current consecutive-hit count
- max_combo  out  8  longest combo so far
- hit_count  out  8  total hits
- miss_count  out  8  total misses
- grade  out  2  3=S, 2=A, 1=B, 0=C; valid only when results_valid=1
- results_valid  out  1  final results stable

Behaviour:
- Reset values: all outputs 0. Internal prev_active, prev_hit, pending and state are also cleared, and state goes to PLAY.
- Inputs are synchronous to clk and sampled every clk, with no dependence on frame ticks.
- Per-lane events, registered each cycle:
  - hit_ev[i] = note_hit[i] & ~prev_hit[i]
  - miss_ev[i] = prev_active[i] & ~note_active[i] & ~prev_hit[i]
  - A hit note whose flags clear together yields no event.
- nh = popcount(hit_ev), 0..4; nm = popcount(miss_ev).
- Counts: hit_count += nh and miss_count += nm, each saturating at 255.
- Combo:
  - if nm>0, combo <= 0, even when nh>0 in the same cycle;
  - else combo <= min(combo+nh, 255).
  - max_combo <= max(max_combo, next combo).
- Points:
  - each hit adds POINTS_PER_HIT;
  - if combo+nh >= COMBO_BONUS_THRESH and nm=0, each hit also adds COMBO_BONUS_POINTS;
  - the total is added to a 12-bit binary pending register, saturating at 4095.
- Drain: while pending>0, one clk moves one point from pending into the BCD score; pending decrements by 1.
- BCD score saturates at 9999. At saturation, pending still drains to 0 without changing the score.
- Events keep being accepted while draining, and the accumulate and decrement combine in the same cycle.
- State machine:
  - PLAY: event processing. A rising edge of chart_done goes to TALLY. If chart_done is already high when PLAY is entered after reset, that also counts as a rise.
  - TALLY: events still processed. The FSM waits for pending=0 and then an additional clk with no events before computing the grade.
  - Grade rule: miss_count=0 gives S; miss_count≤GRADE_A_MAX_MISS gives A; miss_count≤GRADE_B_MAX_MISS gives B; otherwise C. grade is registered and the FSM goes to DONE.
  - DONE: results_valid=1. All counters and outputs are frozen and input events are ignored. Exit is by rst only.
- Latency:
  - input edge to counts/combo: 2 clk (event register, then update);
  - event to score change: ≥3 clk, plus 1 clk per point.
- Reset mid-operation clears everything immediately; pending points are discarded.

Optional Feature:
- Macro: SCORE_KEEPER_FULL_COMBO_EN.
- With the macro, on TALLY entry:
  - if miss_count=0 and hit_count>0, FC_BONUS is added to pending once;
  - the grade waits for that bonus to drain.
- Without the macro, there is no bonus and the FC_BONUS parameter is unused.

Decomposition:
- Package score_pkg holds:
  - the grade encodings GRADE_S/A/B/C;
  - the state enum PLAY/TALLY/DONE;
  - BCD_MAX=16'h9999 and the pending width constant.
- Sub-module bcd_counter4: 4-digit BCD up-counter with enable, saturating at 9999 and exposing an at_max flag.
- Popcount and grade compare stay inline.

Test Plan:
- Single lane-0 hit (note_hit 0→1 while active, then both drop together) -> hit_count=1, combo=1, miss_count=0, score_bcd=16'h0010 after drain.
- Lane-2 note deactivates with note_hit=0 after combo=5 -> miss_count=1, combo=0, max_combo=5, score unchanged.
- 8 consecutive single hits -> the 8th earns the bonus; combo=8, score_bcd=16'h0085.
- Lanes 0 and 1 hit in the same cycle as a lane-3 miss -> hit_count+=2, miss_count+=1, combo=0, pending +20.
- Score preloaded near saturation, then 10 hits -> score_bcd holds 16'h9999 and pending drains to 0.
- chart_done rises with pending>0 and 3 misses total:
  - grade=1 (B) and results_valid=1 only after pending=0;
  - later note_hit edges are ignored;
  - with SCORE_KEEPER_FULL_COMBO_EN and 0 misses, grade=3 and score includes +100.

Source files
------------

// File: rtl/score_keeper_pkg.sv
// Shared types and constants for the score_keeper judgement stage.
package score_pkg;

  localparam logic [1:0] GRADE_S = 2'd3;
  localparam logic [1:0] GRADE_A = 2'd2;
  localparam logic [1:0] GRADE_B = 2'd1;
  localparam logic [1:0] GRADE_C = 2'd0;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    TALLY = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [15:0]       BCD_MAX  = 16'h9999;
  localparam int unsigned       PEND_W   = 12;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  // 8-bit counter plus a 0..4 event count, clamped at 255
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [2:0] b);
    logic [8:0] s;
    s = 9'(a) + 9'(b);
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/score_keeper_bcd_counter4.sv
// 4-digit BCD up-counter with enable; holds at 9999 and flags it via o_at_max.
module bcd_counter4
  import score_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  output logic [15:0] o_value,
  output logic        o_at_max
);

  logic [15:0] r_value;
  logic [15:0] w_next;
  logic        w_carry;

  // Ripple a +1 through the digits, wrapping 9 to 0 with carry
  always_comb begin
    w_next  = r_value;
    w_carry = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (w_carry) begin
        if (r_value[d*4 +: 4] == 4'd9) begin
          w_next[d*4 +: 4] = 4'd0;
        end else begin
          w_next[d*4 +: 4] = r_value[d*4 +: 4] + 4'd1;
          w_carry          = 1'b0;
        end
      end
    end
  end

  assign o_at_max = (r_value == BCD_MAX);
  assign o_value  = r_value;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value <= '0;
    end else if (i_en && !o_at_max) begin
      r_value <= w_next;
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Hit/miss judgement, combo tracking, BCD score drain and end-of-chart grading.
// Optional full-combo bonus enabled by defining SCORE_KEEPER_FULL_COMBO_EN.
module score_keeper
  import score_pkg::*;
#(
  parameter int unsigned POINTS_PER_HIT     = 10,
  parameter int unsigned COMBO_BONUS_THRESH = 8,
  parameter int unsigned COMBO_BONUS_POINTS = 5,
  parameter int unsigned GRADE_A_MAX_MISS   = 2,
  parameter int unsigned GRADE_B_MAX_MISS   = 8,
  parameter int unsigned FC_BONUS           = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  note_active,
  input  logic [3:0]  note_hit,
  input  logic        chart_done,
  output logic [15:0] score_bcd,
  output logic [7:0]  combo,
  output logic [7:0]  max_combo,
  output logic [7:0]  hit_count,
  output logic [7:0]  miss_count,
  output logic [1:0]  grade,
  output logic        results_valid
);

  localparam int unsigned SUM_W = PEND_W + 8;

  logic [3:0]        r_prev_active, r_prev_hit, r_hit_ev, r_miss_ev;
  logic              r_prev_done;
  logic [PEND_W-1:0] r_pending;
  logic [7:0]        r_combo, r_max_combo, r_hit_count, r_miss_count;
  logic [1:0]        r_grade;
  logic              r_results_valid, r_settle;
  state_e            r_state;

  logic [2:0]        w_nh, w_nm;
  logic [8:0]        w_combo_sum;
  logic              w_bonus, w_drain, w_accept, w_at_max, w_quiet;
  logic [SUM_W-1:0]  w_per, w_pts, w_pend_sum;
  logic [PEND_W-1:0] w_pend_sat, w_pend_next;
  logic [7:0]        w_combo_next, w_max_next, w_hit_next, w_miss_next;
  state_e            w_state_nxt;
  logic              w_settle_nxt, w_valid_nxt, w_fc_add;
  logic [1:0]        w_grade_nxt;

  // Per-lane edge detection; events are registered one clk after the input change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_active <= '0;
      r_prev_hit    <= '0;
      r_hit_ev      <= '0;
      r_miss_ev     <= '0;
      r_prev_done   <= 1'b0;
    end else begin
      r_prev_active <= note_active;
      r_prev_hit    <= note_hit;
      r_hit_ev      <= note_hit & ~r_prev_hit;
      r_miss_ev     <= r_prev_active & ~note_active & ~r_prev_hit;
      r_prev_done   <= chart_done;
    end
  end

  assign w_nh = 3'(r_hit_ev[0]) + 3'(r_hit_ev[1]) + 3'(r_hit_ev[2]) + 3'(r_hit_ev[3]);
  assign w_nm = 3'(r_miss_ev[0]) + 3'(r_miss_ev[1]) + 3'(r_miss_ev[2]) + 3'(r_miss_ev[3]);

  assign w_accept     = (r_state != DONE);
  assign w_combo_sum  = 9'(r_combo) + 9'(w_nh);
  assign w_bonus      = (w_combo_sum >= 9'(COMBO_BONUS_THRESH)) && (w_nm == 3'd0);
  assign w_per        = SUM_W'(POINTS_PER_HIT) + (w_bonus ? SUM_W'(COMBO_BONUS_POINTS) : '0);
  assign w_pts        = SUM_W'(w_nh) * w_per;
  assign w_combo_next = (w_nm != 3'd0) ? 8'd0 : sat_add8(r_combo, w_nh);
  assign w_max_next   = (w_combo_next > r_max_combo) ? w_combo_next : r_max_combo;
  assign w_hit_next   = sat_add8(r_hit_count, w_nh);
  assign w_miss_next  = sat_add8(r_miss_count, w_nm);

  // Accumulate and drain share the cycle; the drain always uses the old value
  assign w_drain     = (r_pending != '0);
  assign w_pend_sum  = SUM_W'(r_pending) + w_pts + (w_fc_add ? SUM_W'(FC_BONUS) : '0);
  assign w_pend_sat  = (w_pend_sum > SUM_W'(PEND_MAX)) ? PEND_MAX : PEND_W'(w_pend_sum);
  assign w_pend_next = w_pend_sat - PEND_W'(w_drain);
  assign w_quiet     = !w_drain && (w_nh == 3'd0) && (w_nm == 3'd0);

  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = 1'b0;
    w_valid_nxt  = r_results_valid;
    w_grade_nxt  = r_grade;
    w_fc_add     = 1'b0;
    unique case (r_state)
      PLAY: begin
        if (chart_done && !r_prev_done) begin
          w_state_nxt = TALLY;
`ifdef SCORE_KEEPER_FULL_COMBO_EN
          w_fc_add = (w_miss_next == 8'd0) && (w_hit_next != 8'd0);
`endif
        end
      end
      TALLY: begin
        // Grade only after pending has drained and one further event-free clk
        w_settle_nxt = w_quiet;
        if (w_quiet && r_settle) begin
          w_state_nxt = DONE;
          w_valid_nxt = 1'b1;
          if (r_miss_count == 8'd0)                         w_grade_nxt = GRADE_S;
          else if (r_miss_count <= 8'(GRADE_A_MAX_MISS))    w_grade_nxt = GRADE_A;
          else if (r_miss_count <= 8'(GRADE_B_MAX_MISS))    w_grade_nxt = GRADE_B;
          else                                              w_grade_nxt = GRADE_C;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= PLAY;
      r_settle        <= 1'b0;
      r_grade         <= GRADE_C;
      r_results_valid <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_settle        <= w_settle_nxt;
      r_grade         <= w_grade_nxt;
      r_results_valid <= w_valid_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending    <= '0;
      r_combo      <= '0;
      r_max_combo  <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (w_accept) begin
      r_pending    <= w_pend_next;
      r_combo      <= w_combo_next;
      r_max_combo  <= w_max_next;
      r_hit_count  <= w_hit_next;
      r_miss_count <= w_miss_next;
    end
  end

  bcd_counter4 u_score (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_drain && w_accept && !w_at_max),
    .o_value  (score_bcd),
    .o_at_max (w_at_max)
  );

  assign combo         = r_combo;
  assign max_combo     = r_max_combo;
  assign hit_count     = r_hit_count;
  assign miss_count    = r_miss_count;
  assign grade         = r_grade;
  assign results_valid = r_results_valid;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with an integer-arithmetic reference model.
module tb_score_keeper;

  logic        clk;
  logic        rst;
  logic [3:0]  note_active;
  logic [3:0]  note_hit;
  logic        chart_done;
  logic [15:0] score_bcd;
  logic [7:0]  combo, max_combo, hit_count, miss_count;
  logic [1:0]  grade;
  logic        results_valid;

  int checks = 0;
  int errors = 0;

  score_keeper dut (
    .clk           (clk),
    .rst           (rst),
    .note_active   (note_active),
    .note_hit      (note_hit),
    .chart_done    (chart_done),
    .score_bcd     (score_bcd),
    .combo         (combo),
    .max_combo     (max_combo),
    .hit_count     (hit_count),
    .miss_count    (miss_count),
    .grade         (grade),
    .results_valid (results_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Reference model: plain integers following the scoring rules
  int         m_hits, m_miss, m_combo, m_max, m_score, m_pend, m_grade, m_phase;
  bit         m_valid, m_settle, m_pdone;
  logic [3:0] m_ph, m_pa, m_hev, m_mev;
  int         nh, nm, pts, old_p;
  bit         quiet;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hits = 0; m_miss = 0; m_combo = 0; m_max = 0; m_score = 0; m_pend = 0;
      m_grade = 0; m_phase = 0; m_valid = 0; m_settle = 0; m_pdone = 0;
      m_ph = 0; m_pa = 0; m_hev = 0; m_mev = 0;
    end else begin
      nh = $countones(m_hev);
      nm = $countones(m_mev);
      old_p = m_pend;
      if (m_phase != 2) begin
        pts = nh * (10 + ((m_combo + nh >= 8 && nm == 0) ? 5 : 0));
        m_hits  = imin(m_hits + nh, 255);
        m_miss  = imin(m_miss + nm, 255);
        m_combo = (nm > 0) ? 0 : imin(m_combo + nh, 255);
        if (m_combo > m_max) m_max = m_combo;
        if (m_phase == 0 && chart_done && !m_pdone) begin
          m_phase = 1;
`ifdef SCORE_KEEPER_FULL_COMBO_EN
          if (m_miss == 0 && m_hits > 0) pts = pts + 100;
`endif
        end else if (m_phase == 1) begin
          quiet = (old_p == 0 && nh == 0 && nm == 0);
          if (quiet && m_settle) begin
            m_phase = 2;
            m_valid = 1;
            m_grade = (m_miss == 0) ? 3 : (m_miss <= 2) ? 2 : (m_miss <= 8) ? 1 : 0;
          end
          m_settle = quiet;
        end
        m_pend = imin(old_p + pts, 4095);
        if (old_p > 0) begin
          m_pend = m_pend - 1;
          if (m_score < 9999) m_score = m_score + 1;
        end
      end
      m_hev = note_hit & ~m_ph;
      m_mev = m_pa & ~note_active & ~m_ph;
      m_ph  = note_hit;
      m_pa  = note_active;
      m_pdone = chart_done;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("score_bcd", score_bcd, to_bcd(m_score));
      chk("combo", combo, m_combo);
      chk("max_combo", max_combo, m_max);
      chk("hit_count", hit_count, m_hits);
      chk("miss_count", miss_count, m_miss);
      chk("results_valid", results_valid, m_valid);
      if (m_valid) chk("grade", grade, m_grade);
    end
  end

  task automatic drive(input logic [3:0] a, input logic [3:0] h, input int n);
    note_active = a;
    note_hit    = h;
    repeat (n) @(negedge clk);
  endtask

  task automatic hit(input logic [3:0] lanes);
    drive(lanes, 4'b0, 1);
    drive(lanes, lanes, 1);
    drive(4'b0, 4'b0, 1);
  endtask

  task automatic miss(input logic [3:0] lanes);
    drive(lanes, 4'b0, 1);
    drive(4'b0, 4'b0, 1);
  endtask

  task automatic do_reset(input logic done_level);
    @(negedge clk);
    rst = 1'b1;
    note_active = 4'b0;
    note_hit = 4'b0;
    chart_done = done_level;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!results_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("results_valid_timeout", results_valid, 1);
  endtask

  initial begin
    int k;
    int rounds;
    rst = 1'b1;
    note_active = 4'b0;
    note_hit = 4'b0;
    chart_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_score", score_bcd, 16'h0000);
    chk("rst_combo", combo, 0);
    chk("rst_valid", results_valid, 0);

    // Single lane-0 hit, then four more and a lane-2 miss
    hit(4'b0001);
    drive(4'b0, 4'b0, 20);
    chk("t1_hits", hit_count, 1);
    chk("t1_combo", combo, 1);
    chk("t1_miss", miss_count, 0);
    chk("t1_score", score_bcd, 16'h0010);
    repeat (4) hit(4'b0001);
    miss(4'b0100);
    drive(4'b0, 4'b0, 60);
    chk("t2_miss", miss_count, 1);
    chk("t2_combo", combo, 0);
    chk("t2_max", max_combo, 5);
    chk("t2_score", score_bcd, 16'h0050);

    // Eight hits: the eighth earns the combo bonus
    do_reset(1'b0);
    repeat (8) hit(4'b0001);
    drive(4'b0, 4'b0, 120);
    chk("t3_combo", combo, 8);
    chk("t3_score", score_bcd, 16'h0085);

    // Two hits with a simultaneous miss: no bonus, combo broken
    drive(4'b1011, 4'b0000, 1);
    drive(4'b0011, 4'b0011, 1);
    drive(4'b0000, 4'b0000, 40);
    chk("t4_hits", hit_count, 10);
    chk("t4_miss", miss_count, 1);
    chk("t4_combo", combo, 0);
    chk("t4_score", score_bcd, 16'h0105);

    // Reset mid-drain discards pending points
    repeat (3) hit(4'b1111);
    do_reset(1'b0);
    chk("t5_rst_score", score_bcd, 16'h0000);
    chk("t5_rst_hits", hit_count, 0);

    // Run the score up to near 9999, then overflow it
    rounds = 0;
    while (m_score + m_pend < 9930 && rounds < 400) begin
      hit(4'b1111);
      k = 0;
      while (m_pend > 20 && k < 200) begin
        drive(4'b0, 4'b0, 1);
        k++;
      end
      rounds++;
    end
    drive(4'b0, 4'b0, 100);
    repeat (10) hit(4'b0001);
    drive(4'b0, 4'b0, 300);
    chk("t5_score_sat", score_bcd, 16'h9999);
    chk("t5_hits_sat", hit_count, 255);
    chk("t5_combo_sat", combo, 255);
    chk("t5_max_sat", max_combo, 255);
    chart_done = 1'b1;
    wait_valid(100);
    chk("t5_grade", grade, 3);

    // chart_done rises with pending > 0 and three misses
    do_reset(1'b0);
    repeat (3) hit(4'b0001);
    repeat (3) miss(4'b0010);
    hit(4'b0001);
    drive(4'b0001, 4'b0000, 1);
    drive(4'b0001, 4'b0001, 1);
    chart_done = 1'b1;
    drive(4'b0000, 4'b0000, 1);
    chk("t6_valid_early", results_valid, 0);
    wait_valid(200);
    chk("t6_grade", grade, 1);
    chk("t6_miss", miss_count, 3);
    hit(4'b0001);
    miss(4'b0100);
    drive(4'b0, 4'b0, 10);
    chk("t6_hits_frozen", hit_count, 5);
    chk("t6_miss_frozen", miss_count, 3);
    chk("t6_score", score_bcd, 16'h0050);
    chk("t6_valid_held", results_valid, 1);

    // chart_done already high when reset releases
    do_reset(1'b1);
    wait_valid(20);
    chk("t7_grade", grade, 3);
    chk("t7_score", score_bcd, 16'h0000);

    // Clean run: grade S, full-combo bonus when enabled
    do_reset(1'b0);
    repeat (2) hit(4'b0001);
    drive(4'b0, 4'b0, 30);
    chart_done = 1'b1;
    wait_valid(300);
    drive(4'b0, 4'b0, 5);
    chk("t8_grade", grade, 3);
`ifdef SCORE_KEEPER_FULL_COMBO_EN
    chk("t8_score", score_bcd, 16'h0120);
`else
    chk("t8_score", score_bcd, 16'h0020);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
